// File: rtl/mux3_arbiter_pkg.sv
// Shared types for the 3-way round-robin grant arbiter.
// Mux select encodings, FSM state type and small grant helpers.
package mux3_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam logic [1:0] SEL_A    = 2'b00;
    localparam logic [1:0] SEL_B    = 2'b01;
    localparam logic [1:0] SEL_C    = 2'b10;
    localparam logic [1:0] SEL_IDLE = 2'b11;

    localparam logic [2:0] GNT_NONE = 3'b000;

    function automatic logic [2:0] sel2gnt(input logic [1:0] s);
        logic [2:0] g;
        g = GNT_NONE;
        unique case (1'b1)
            (s == SEL_A): g = 3'b001;
            (s == SEL_B): g = 3'b010;
            (s == SEL_C): g = 3'b100;
            default:      g = GNT_NONE;
        endcase
        return g;
    endfunction

    // Pointer moves one past the owner being released.
    function automatic logic [1:0] next_ptr(input logic [1:0] s);
        logic [1:0] p;
        p = SEL_A;
        unique case (1'b1)
            (s == SEL_A): p = SEL_B;
            (s == SEL_B): p = SEL_C;
            default:      p = SEL_A;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/mux3_arbiter_rr_pick3.sv
// Combinational round-robin pick among three requesters.
// Search order is ptr, ptr+1, ptr+2 (mod 3); first set bit wins.
module rr_pick3
    import mux3_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic       found,
    output logic [1:0] idx
);

    function automatic logic [1:0] wrap3(input logic [2:0] v);
        logic [2:0] r;
        r = (v >= 3'd3) ? (v - 3'd3) : v;
        return r[1:0];
    endfunction

    always_comb begin
        logic [1:0] cand;
        found = 1'b0;
        idx   = SEL_IDLE;
        cand  = SEL_A;
        // Walk from lowest priority to highest so the last hit wins.
        for (int k = 2; k >= 0; k--) begin
            cand = wrap3({1'b0, ptr} + 3'(k));
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux3_arbiter.sv
// Three-requester round-robin arbiter driving a shared 3:1 data mux.
// Holds a grant per burst with a beat cap and abandon release.
module mux3_arbiter
    import mux3_arbiter_pkg::*;
#(
    parameter int MAX_BEATS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic [2:0] req_last,
    input  logic       out_ready,
    output logic [2:0] gnt,
    output logic [1:0] sel,
    output logic       out_valid,
    output logic       busy
);

    localparam int CW = $clog2(MAX_BEATS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BEATS - 1);

    state_e        state_q, state_d;
    logic [2:0]    gnt_q, gnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic       pick_found;
    logic [1:0] pick_idx;
    logic       owner_req;
    logic       owner_last;
    logic       accept;
    logic       release_g;

    rr_pick3 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // gnt_q is zero outside BUSY, so masking selects the owner's bits.
    assign owner_req  = |(req & gnt_q);
    assign owner_last = |(req_last & gnt_q);
    assign accept     = owner_req & out_ready;
    assign release_g  = !owner_req
                      || (accept && (owner_last || cnt_q == CNT_LAST));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (pick_found) begin
                    state_d = ST_BUSY;
                    sel_d   = pick_idx;
                    gnt_d   = sel2gnt(pick_idx);
                end
            end
            ST_BUSY: begin
                if (release_g) begin
                    state_d = ST_IDLE;
                    gnt_d   = GNT_NONE;
                    sel_d   = SEL_IDLE;
                    ptr_d   = next_ptr(sel_q);
                    cnt_d   = '0;
                end else if (accept) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = GNT_NONE;
                sel_d   = SEL_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= GNT_NONE;
            sel_q   <= SEL_IDLE;
            ptr_q   <= SEL_A;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign busy      = (state_q == ST_BUSY);
    assign out_valid = owner_req;

endmodule

// File: tb/tb_mux3_arbiter.sv
// Randomized bench for mux3_arbiter with an owner/pointer/beat model.
// Directed scenarios pin the model with literal select sequences.
module tb_mux3_arbiter;

    localparam int MB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] req = 3'b000;
    logic [2:0] req_last = 3'b000;
    logic       out_ready = 1'b0;
    logic [2:0] gnt;
    logic [1:0] sel;
    logic       out_valid;
    logic       busy;

    int errs = 0;
    int checks = 0;

    int m_owner = -1;
    int m_ptr = 0;
    int m_beats = 0;

    mux3_arbiter #(.MAX_BEATS(MB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_last  (req_last),
        .out_ready (out_ready),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act,
                       input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic m_release();
        m_ptr   = (m_owner + 1) % 3;
        m_owner = -1;
        m_beats = 0;
    endtask

    // Compare outputs against the model, then advance the model with
    // the inputs that the next rising edge will sample.
    always @(negedge clk) begin
        int i;
        logic [2:0] eg;
        logic [1:0] es;
        logic       ev;
        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = 0;
            m_beats = 0;
            chk("rst_gnt", {1'b0, gnt}, 4'd0);
            chk("rst_sel", {2'b0, sel}, 4'd3);
            chk("rst_valid", {3'b0, out_valid}, 4'd0);
            chk("rst_busy", {3'b0, busy}, 4'd0);
        end else begin
            eg = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
            es = (m_owner < 0) ? 2'd3 : 2'(m_owner);
            ev = (m_owner >= 0) && req[m_owner];
            chk("gnt", {1'b0, gnt}, {1'b0, eg});
            chk("sel", {2'b0, sel}, {2'b0, es});
            chk("out_valid", {3'b0, out_valid}, {3'b0, ev});
            chk("busy", {3'b0, busy}, {3'b0, m_owner >= 0});
            if (m_owner < 0) begin
                for (int k = 0; k < 3; k++) begin
                    i = (m_ptr + k) % 3;
                    if (req[i] && m_owner < 0) m_owner = i;
                end
                m_beats = 0;
            end else if (!req[m_owner]) begin
                m_release();
            end else if (out_ready) begin
                m_beats++;
                if (req_last[m_owner] || m_beats == MB) m_release();
            end
        end
    end

    task automatic cyc(input logic [2:0] r, input logic [2:0] l,
                       input logic o);
        @(posedge clk);
        #1;
        req       = r;
        req_last  = l;
        out_ready = o;
    endtask

    task automatic pin(input string n, input logic [1:0] s);
        #1;
        chk(n, {2'b0, sel}, {2'b0, s});
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        req       = 3'b000;
        req_last  = 3'b000;
        out_ready = 1'b0;
        #1;
        chk("reset_now_gnt", {1'b0, gnt}, 4'd0);
        chk("reset_now_sel", {2'b0, sel}, 4'd3);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [1:0] e30 [8] = '{2'd0, 2'd3, 2'd1, 2'd3,
                            2'd2, 2'd3, 2'd0, 2'd3};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All requesting, single-beat bursts: A, B, C, A with gaps.
        do_reset();
        cyc(3'b111, 3'b111, 1'b1); pin("rr_idle", 2'd3);
        for (int n = 0; n < 8; n++) begin
            cyc(3'b111, 3'b111, 1'b1);
            pin($sformatf("rr_seq%0d", n), e30[n]);
        end

        // B alone, three beats; pointer then favours C.
        do_reset();
        cyc(3'b010, 3'b000, 1'b1); pin("b_idle", 2'd3);
        cyc(3'b010, 3'b000, 1'b1); pin("b_beat1", 2'd1);
        cyc(3'b010, 3'b000, 1'b1); pin("b_beat2", 2'd1);
        cyc(3'b010, 3'b010, 1'b1); pin("b_beat3", 2'd1);
        cyc(3'b111, 3'b000, 1'b0); pin("b_rel", 2'd3);
        cyc(3'b111, 3'b000, 1'b0); pin("b_next_c", 2'd2);

        // Beat cap of 4 on A, then C wins.
        do_reset();
        cyc(3'b101, 3'b000, 1'b1); pin("cap_idle", 2'd3);
        for (int n = 0; n < 4; n++) begin
            cyc(3'b101, 3'b000, 1'b1);
            pin($sformatf("cap_a%0d", n), 2'd0);
        end
        cyc(3'b101, 3'b000, 1'b1); pin("cap_rel", 2'd3);
        cyc(3'b101, 3'b000, 1'b1); pin("cap_next_c", 2'd2);

        // Stalled consumer with req_last held does not release.
        do_reset();
        cyc(3'b001, 3'b001, 1'b0); pin("stall_idle", 2'd3);
        for (int n = 0; n < 5; n++) begin
            cyc(3'b001, 3'b001, 1'b0);
            pin($sformatf("stall%0d", n), 2'd0);
        end
        cyc(3'b001, 3'b001, 1'b1); pin("stall_go", 2'd0);
        cyc(3'b000, 3'b000, 1'b0); pin("stall_rel", 2'd3);

        // A abandons after two beats; B is next.
        do_reset();
        cyc(3'b001, 3'b000, 1'b1); pin("ab_idle", 2'd3);
        cyc(3'b001, 3'b000, 1'b1); pin("ab_beat1", 2'd0);
        cyc(3'b001, 3'b000, 1'b1); pin("ab_beat2", 2'd0);
        cyc(3'b110, 3'b000, 1'b0); pin("ab_drop", 2'd0);
        chk("ab_valid", {3'b0, out_valid}, 4'd0);
        cyc(3'b110, 3'b000, 1'b0); pin("ab_rel", 2'd3);
        cyc(3'b110, 3'b000, 1'b0); pin("ab_next_b", 2'd1);

        // Reset mid C burst; A first afterwards.
        do_reset();
        cyc(3'b100, 3'b000, 1'b1); pin("rc_idle", 2'd3);
        cyc(3'b100, 3'b000, 1'b1); pin("rc_c", 2'd2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rc_gnt", {1'b0, gnt}, 4'd0);
        chk("rc_sel", {2'b0, sel}, 4'd3);
        chk("rc_busy", {3'b0, busy}, 4'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req       = 3'b111;
        req_last  = 3'b111;
        out_ready = 1'b1;
        cyc(3'b111, 3'b111, 1'b1); pin("rc_a_first", 2'd0);

        // Random traffic with occasional reset pulses.
        for (int n = 0; n < 4000; n++) begin
            @(posedge clk);
            #1;
            rst_n = ($urandom_range(0, 249) != 0);
            for (int b = 0; b < 3; b++) begin
                req[b]      = ($urandom_range(0, 9) < 8);
                req_last[b] = ($urandom_range(0, 9) < 3);
            end
            out_ready = ($urandom_range(0, 9) < 7);
        end

        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mux3_arbiter.md
MUX3_ARBITER -- requirements
Module: mux3_arbiter

Interface
REQ-001: Parameter MAX_BEATS, default 8, SHALL be the maximum beats one grant may carry before forced release; legal range is 1..255.
REQ-002: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003: rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-004: req  input  3  SHALL carry per-requester request/valid; bit i belongs to requester i (0=A, 1=B, 2=C).
REQ-005: req_last  input  3  SHALL mark, per requester, that the current beat is the final beat of its burst.
REQ-006: out_ready  input  1  SHALL indicate that the shared consumer accepts a beat this cycle.
REQ-007: gnt  output  3  SHALL be the registered one-hot grant; all-zero when no owner.
REQ-008: sel  output  2  SHALL drive the shared 3:1 data mux select: 00=A, 01=B, 10=C, 11=idle, which yields mux output 0.
REQ-009: out_valid  output  1  SHALL be req[owner] while a grant is held, and 0 otherwise.
REQ-010: busy  output  1  SHALL be 1 exactly when the FSM is in BUSY.

Function
REQ-011: FSM SHALL have two states: IDLE and BUSY.
REQ-012: In IDLE, gnt=000, sel=11, out_valid=0.
REQ-013: In IDLE, if any req bit is 1 in cycle N, the arbiter SHALL pick the owner by round-robin and present gnt/sel for it from cycle N+1 (state BUSY).
REQ-014: Round-robin search SHALL start at pointer ptr and proceed ptr, ptr+1, ptr+2 mod 3; the first set req bit wins.
REQ-015: A beat SHALL be accepted in any BUSY cycle where out_valid=1 and out_ready=1; beat_cnt increments by 1 on each accept.
REQ-016: The grant SHALL be released, returning to IDLE next cycle, on an accepted beat where req_last[owner]=1.
REQ-017: The grant SHALL also be released on an accepted beat where beat_cnt equals MAX_BEATS-1 (starvation cap), regardless of req_last.
REQ-018: The grant SHALL also be released in any BUSY cycle where req[owner]=0 (abandon); no beat is counted that cycle.
REQ-019: On any release, ptr SHALL become (owner+1) mod 3 and beat_cnt SHALL clear to 0.
REQ-020: After every release, at least one IDLE cycle SHALL separate consecutive grants.
REQ-021: Request changes by non-owners during BUSY SHALL NOT affect gnt, sel or beat_cnt.
REQ-022: req_last on a non-accepted cycle (out_ready=0) SHALL NOT cause release.
REQ-023: gnt and sel SHALL always be consistent: gnt[i]=1 iff sel=i; gnt=000 iff sel=11.
REQ-024: beat_cnt width SHALL be ceil(log2(MAX_BEATS+1)) bits; it SHALL never exceed MAX_BEATS-1.

Reset
REQ-025: While rst_n=0, state=IDLE, gnt=000, sel=11, out_valid=0, busy=0, ptr=0, beat_cnt=0, taking effect immediately without a clock edge.
REQ-026: Reset asserted mid-burst SHALL drop the grant at once; after deassertion, arbitration SHALL restart with requester A highest priority.

Structure
REQ-027: Sel encodings (SEL_A, SEL_B, SEL_C, SEL_IDLE) and the FSM state type SHALL live in the shared core types file.
REQ-028: Round-robin pick logic SHALL be a combinational sub-module rr_pick3 (inputs req, ptr; outputs found and idx).
REQ-029: gnt, sel, ptr, beat_cnt and state SHALL be registers; out_valid SHALL be the only combinational output path from req.

Verification
REQ-030: Reset, then req=111 held, req_last=111, out_ready=1 -> grants A, B, C, A in order, each one cycle BUSY with an IDLE cycle between grants.
REQ-031: Only B requests, 3 beats, last on beat 3, out_ready=1 -> sel=01 for 3 cycles, then sel=11; ptr=2.
REQ-032: MAX_BEATS=4, A requests with req_last=0 forever, out_ready=1 -> release after the 4th accepted beat; with C also requesting, C is granted next.
REQ-033: A owns, out_ready=0 for 5 cycles with req_last=1 -> no release, beat_cnt=0; first out_ready=1 releases.
REQ-034: A owns, req[0] drops after 2 beats -> return to IDLE next cycle, ptr=1, beat_cnt=0.
REQ-035: rst_n pulsed low during a C burst -> gnt=000, sel=11 immediately; with req=111 after release, A is granted first.
